// File: rtl/if_id_buffer.sv
// Elastic IF/ID pipeline buffer: a small circular FIFO of {PC, instruction} pairs
// between fetch and decode, with full back-pressure and taken-branch flush.
module if_id_buffer #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instruction,
  input  logic              if_valid,
  output logic              if_freeze,
  input  logic              flush,
  input  logic              id_stall,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instruction,
  output logic              id_valid,
  output logic [PTR_W:0]    occupancy
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] pc_mem_r    [DEPTH];
  logic [DATA_W-1:0] instr_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [PTR_W:0]    count_next_s;
  logic              push_s;
  logic              pop_s;

  // Status and head-of-queue outputs; an empty buffer presents an all-zero bubble.
  always_comb begin
    if_freeze      = (count_r == COUNT_MAX);
    id_valid       = (count_r != {(PTR_W + 1){1'b0}});
    occupancy      = count_r;
    id_pc          = {DATA_W{1'b0}};
    id_instruction = {DATA_W{1'b0}};
    if (id_valid) begin
      id_pc          = pc_mem_r[rd_ptr_r];
      id_instruction = instr_mem_r[rd_ptr_r];
    end else begin
      id_pc          = {DATA_W{1'b0}};
      id_instruction = {DATA_W{1'b0}};
    end
  end

  // Handshake decode and next occupancy; freeze depends on count alone, so a
  // pop while full cannot make room for a push in the same cycle.
  always_comb begin
    push_s       = if_valid & ~if_freeze & ~flush;
    pop_s        = id_valid & ~id_stall & ~flush;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + COUNT_ONE;
      2'b01:   count_next_s = count_r - COUNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and count state; reset outranks flush, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      pc_mem_r[wr_ptr_r]    <= if_pc;
      instr_mem_r[wr_ptr_r] <= if_instruction;
    end
  end

endmodule
